// File: rtl/sr_latch_ctrl_if.sv
// Bundle of requester handshake and SR-latch drive/readback signals for sr_latch_ctrl.
// The controller is the slave side; the requesters plus the latch make up the master side.
interface sr_latch_ctrl_if #(
  parameter int N = 4
);
  logic [N-1:0] set_req;
  logic [N-1:0] clr_req;
  logic [N-1:0] ack;
  logic         q;
  logic         s;
  logic         r;
  logic         busy;
  logic         err;

  modport master (
    output set_req, clr_req, q,
    input  s, r, ack, busy, err
  );

  modport slave (
    input  set_req, clr_req, q,
    output s, r, ack, busy, err
  );
endinterface

// File: rtl/sr_latch_ctrl.sv
// Round-robin controller sharing one SR latch between N requesters.
// It pulses s or r for PULSE_W cycles, settles for GAP cycles, then checks q and acks.
module sr_latch_ctrl #(
  parameter int N       = 4,
  parameter int PULSE_W = 2,
  parameter int GAP     = 1
) (
  input  logic            clk,
  input  logic            rst,
  sr_latch_ctrl_if.slave  bus
);

  localparam int PW   = (N > 1) ? $clog2(N) : 1;
  localparam int MAXC = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP, ST_CHECK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   g_q, g_d;
  logic            t_q, t_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic [N-1:0]    ack_q, ack_d;

  logic [N-1:0]    elig;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   gsel;
  logic            found;

  // A requester asking for both set and clear is ignored entirely.
  always_comb begin
    elig  = bus.set_req ^ bus.clr_req;
    found = 1'b0;
    gsel  = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gsel  = idx;
      end
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    t_d     = t_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    ack_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          g_d   = gsel;
          t_d   = bus.set_req[gsel];
          ptr_d = PW'((int'(gsel) + 1) % N);
          if (bus.q == bus.set_req[gsel]) begin
            state_d     = ST_CHECK;
            ack_d[gsel] = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            cnt_d   = CW'(1);
            // s and r are always complementary under a single target bit, never both high.
            s_d     = bus.set_req[gsel];
            r_d     = !bus.set_req[gsel];
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CW'(PULSE_W)) begin
          if (GAP == 0) begin
            state_d    = ST_CHECK;
            ack_d[g_q] = 1'b1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = CW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          s_d   = t_q;
          r_d   = !t_q;
        end
      end
      ST_GAP: begin
        if (cnt_q == CW'(GAP)) begin
          state_d    = ST_CHECK;
          ack_d[g_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      g_q     <= '0;
      t_q     <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      t_q     <= t_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.s    = s_q;
  assign bus.r    = r_q;
  assign bus.ack  = ack_q;
  assign bus.busy = (state_q != ST_IDLE);
  // err reflects the live readback during the single CHECK cycle.
  assign bus.err  = (state_q == ST_CHECK) && (bus.q != t_q);

endmodule
